// File: rtl/eth_frame_tx.sv
// ---------------------------------------------------------------------------
// eth_frame_tx
//
// Byte-serial Ethernet-style frame generator. One complete payload is
// buffered from the host byte stream. When the downstream receiver reports
// idle, the block emits one frame with no gaps:
//   preamble (7 x 0xAA), SFD (0xAB), destination MAC, source MAC (LSB byte
//   first), 16-bit length (high byte first), payload, and 4 x LRC FCS byte.
// The FCS is the two's complement of the mod-256 sum of every MAC, length
// and payload byte.
//
// Optional feature: define ETH_TX_PAD_EN to pad payloads shorter than 46
// bytes with 0x00 up to 46. The length field then carries the padded length.
//
// Ports
//   clk         single clock
//   rst         asynchronous, active-low reset
//   pl_data     payload byte from host
//   pl_vld      pl_data valid
//   pl_last     final payload byte, qualified by pl_vld
//   pl_rdy      block accepts a payload byte
//   sink_ready  downstream receiver idle, sampled only while waiting
//   data        frame byte stream (0x00 when no frame byte is driven)
//   start       frame-start pulse on the first preamble byte
//   busy        a frame is being transmitted
//   done        one-cycle pulse after the last FCS byte
//   err         one-cycle pulse when a payload overflows the buffer
// ---------------------------------------------------------------------------
module eth_frame_tx #(
    parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
    parameter logic [47:0] SRC_MAC_ADDR  = 48'h00_0a_95_00_00_01,
    parameter int          DEPTH         = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pl_data,
    input  logic       pl_vld,
    input  logic       pl_last,
    output logic       pl_rdy,
    input  logic       sink_ready,
    output logic [7:0] data,
    output logic       start,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_PREAMBLE,
        S_SFD,
        S_MACDST,
        S_MACSRC,
        S_PLLEN,
        S_PL,
        S_FCS,
        S_DONE
    } state_t;

    state_t         state;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [15:0]    rd_ptr;
    logic [15:0]    len;
    logic [15:0]    tx_len;
    logic [2:0]     cnt;
    logic [7:0]     sum;
    logic [7:0]     fcs;
    logic [7:0]     pl_byte;
    logic           loading;
    logic           store;

    // Byte k of a MAC address, least-significant byte first.
    function automatic logic [7:0] mac_byte(input logic [47:0] addr, input logic [2:0] k);
        return addr[{k, 3'b000} +: 8];
    endfunction

    // LRC: the value that brings the running byte sum to zero mod 256.
    function automatic logic [7:0] lrc_fcs(input logic [7:0] s);
        return (~s) + 8'd1;
    endfunction

`ifdef ETH_TX_PAD_EN
    localparam logic [15:0] MIN_PL = 16'd46;
    assign tx_len = (len < MIN_PL) ? MIN_PL : len;
`else
    assign tx_len = len;
`endif

    assign loading = (state == S_IDLE) || (state == S_LOAD);
    assign store   = loading && pl_vld && pl_rdy && (len != DEPTH_LEN);

    // Positions past the buffered count are pad bytes and read as zero.
    assign pl_byte = (rd_ptr < len) ? mem[rd_ptr[AW-1:0]] : 8'h00;

    // Payload buffer: data only, no reset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= pl_data;
        end
    end

    // Frame FSM. Every output is registered with the state, so the value on
    // data always belongs to the state currently held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            data   <= 8'h00;
            start  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            pl_rdy <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            cnt    <= '0;
            sum    <= '0;
            fcs    <= '0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE, S_LOAD: begin
                    if (pl_vld && pl_rdy) begin
                        if (len == DEPTH_LEN) begin
                            // No room for any further byte: discard the frame.
                            err    <= 1'b1;
                            wr_ptr <= '0;
                            len    <= '0;
                            state  <= S_IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                            len    <= len + 16'd1;
                            if (pl_last) begin
                                pl_rdy <= 1'b0;
                                state  <= S_WAIT;
                            end else begin
                                state  <= S_LOAD;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (sink_ready) begin
                        state <= S_PREAMBLE;
                        data  <= 8'hAA;
                        start <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                S_PREAMBLE: begin
                    if (cnt == 3'd6) begin
                        state <= S_SFD;
                        data  <= 8'hAB;
                    end else begin
                        cnt   <= cnt + 3'd1;
                        data  <= 8'hAA;
                    end
                end
                S_SFD: begin
                    // Sum restarts here: first summed byte is the first MAC byte.
                    state <= S_MACDST;
                    data  <= mac_byte(DEST_MAC_ADDR, 3'd0);
                    sum   <= mac_byte(DEST_MAC_ADDR, 3'd0);
                    cnt   <= '0;
                end
                S_MACDST: begin
                    if (cnt == 3'd5) begin
                        state <= S_MACSRC;
                        data  <= mac_byte(SRC_MAC_ADDR, 3'd0);
                        sum   <= sum + mac_byte(SRC_MAC_ADDR, 3'd0);
                        cnt   <= '0;
                    end else begin
                        data  <= mac_byte(DEST_MAC_ADDR, cnt + 3'd1);
                        sum   <= sum + mac_byte(DEST_MAC_ADDR, cnt + 3'd1);
                        cnt   <= cnt + 3'd1;
                    end
                end
                S_MACSRC: begin
                    if (cnt == 3'd5) begin
                        state <= S_PLLEN;
                        data  <= tx_len[15:8];
                        sum   <= sum + tx_len[15:8];
                        cnt   <= '0;
                    end else begin
                        data  <= mac_byte(SRC_MAC_ADDR, cnt + 3'd1);
                        sum   <= sum + mac_byte(SRC_MAC_ADDR, cnt + 3'd1);
                        cnt   <= cnt + 3'd1;
                    end
                end
                S_PLLEN: begin
                    if (cnt == 3'd0) begin
                        data  <= tx_len[7:0];
                        sum   <= sum + tx_len[7:0];
                        cnt   <= 3'd1;
                    end else begin
                        // rd_ptr is zero here, so pl_byte is the first payload byte.
                        state  <= S_PL;
                        data   <= pl_byte;
                        sum    <= sum + pl_byte;
                        rd_ptr <= rd_ptr + 16'd1;
                        cnt    <= '0;
                    end
                end
                S_PL: begin
                    if (rd_ptr == tx_len) begin
                        // sum already holds the last payload byte.
                        state <= S_FCS;
                        data  <= lrc_fcs(sum);
                        fcs   <= lrc_fcs(sum);
                        cnt   <= '0;
                    end else begin
                        data   <= pl_byte;
                        sum    <= sum + pl_byte;
                        rd_ptr <= rd_ptr + 16'd1;
                    end
                end
                S_FCS: begin
                    if (cnt == 3'd3) begin
                        state <= S_DONE;
                        data  <= 8'h00;
                        done  <= 1'b1;
                    end else begin
                        data  <= fcs;
                        cnt   <= cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    pl_rdy <= 1'b1;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    len    <= '0;
                    cnt    <= '0;
                    sum    <= '0;
                end
                default: begin
                    state  <= S_IDLE;
                    data   <= 8'h00;
                    busy   <= 1'b0;
                    pl_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_eth_frame_tx
//
// Directed bench for eth_frame_tx (DEPTH = 64, default MAC addresses).
// Scenarios: reset state, basic 4-byte frame, backpressure in WAIT,
// overflow then a 2-byte frame, single-byte / padded frame, reset during
// the payload, and a full 64-byte buffer of random bytes. Expected frames
// come from a small reference model built from the frame format; the basic
// and short frames also carry hand-computed FCS and length values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_frame_tx;

    localparam logic [47:0] DEST  = 48'h00_0a_95_9d_68_16;
    localparam logic [47:0] SRC   = 48'h00_0a_95_00_00_01;
    localparam int          DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pl_data = 8'h00;
    logic       pl_vld = 1'b0;
    logic       pl_last = 1'b0;
    logic       pl_rdy;
    logic       sink_ready = 1'b0;
    logic [7:0] data;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;

    logic [7:0] pay   [0:127];
    logic [7:0] cap   [0:511];
    logic [7:0] exp_b [0:511];
    int         cap_n;
    int         exp_n;
    int         wait_cyc;
    int         start_cnt;
    bit         cap_ok;

    eth_frame_tx #(
        .DEST_MAC_ADDR(DEST),
        .SRC_MAC_ADDR (SRC),
        .DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pl_data   (pl_data),
        .pl_vld    (pl_vld),
        .pl_last   (pl_last),
        .pl_rdy    (pl_rdy),
        .sink_ready(sink_ready),
        .data      (data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) begin
            pl_vld  = 1'b1;
            pl_data = pay[i];
            pl_last = (i == n - 1);
            step();
        end
        pl_vld  = 1'b0;
        pl_last = 1'b0;
        pl_data = 8'h00;
    endtask

    // Waits (bounded) for start, then records data until done is seen.
    task automatic capture_frame();
        cap_ok    = 1'b0;
        wait_cyc  = 0;
        start_cnt = 0;
        cap_n     = 0;
        while (!start && wait_cyc < 200) begin
            step();
            wait_cyc++;
        end
        if (start) begin
            while (!done && cap_n < 500) begin
                cap[cap_n] = data;
                if (start) start_cnt++;
                cap_n++;
                step();
            end
            cap_ok = done;
        end
    endtask

    // Reference frame built from the frame format for payload pay[0..n-1].
    task automatic build_expected(input int n);
        logic [47:0] dm;
        logic [47:0] sm;
        logic [7:0]  s;
        int          l;
        dm = DEST;
        sm = SRC;
        l  = n;
`ifdef ETH_TX_PAD_EN
        if (l < 46) l = 46;
`endif
        exp_n = 0;
        for (int i = 0; i < 7; i++) begin exp_b[exp_n] = 8'hAA; exp_n++; end
        exp_b[exp_n] = 8'hAB; exp_n++;
        for (int k = 0; k < 6; k++) begin exp_b[exp_n] = dm[8*k +: 8]; exp_n++; end
        for (int k = 0; k < 6; k++) begin exp_b[exp_n] = sm[8*k +: 8]; exp_n++; end
        exp_b[exp_n] = 8'(l >> 8); exp_n++;
        exp_b[exp_n] = 8'(l);      exp_n++;
        for (int i = 0; i < l; i++) begin
            exp_b[exp_n] = (i < n) ? pay[i] : 8'h00;
            exp_n++;
        end
        s = 8'h00;
        for (int i = 8; i < exp_n; i++) s = s + exp_b[i];
        for (int i = 0; i < 4; i++) begin exp_b[exp_n] = (~s) + 8'd1; exp_n++; end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        tests++;
        if ({data, start, busy, done, err, pl_rdy} !== {8'h00, 5'b00001}) begin
            fails++;
            $display("FAIL reset_state: got data=%02h start=%b busy=%b done=%b err=%b pl_rdy=%b, expected 00 0 0 0 0 1",
                     data, start, busy, done, err, pl_rdy);
        end
        rst = 1'b1;
        step();
        tests++;
        if ({data, start, busy, pl_rdy} !== {8'h00, 3'b001}) begin
            fails++;
            $display("FAIL idle_after_reset: got data=%02h start=%b busy=%b pl_rdy=%b, expected 00 0 0 1",
                     data, start, busy, pl_rdy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] hand_fcs;
        int         hand_len;
`ifdef ETH_TX_PAD_EN
        hand_fcs = 8'h6E;
        hand_len = 72;
`else
        hand_fcs = 8'h98;
        hand_len = 30;
`endif
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        sink_ready = 1'b1;
        send_payload(4);
        tests++;
        if (pl_rdy !== 1'b0) begin
            fails++;
            $display("FAIL basic_pl_rdy_low: got %b expected 0", pl_rdy);
        end
        build_expected(4);
        capture_frame();
        tests++;
        if (!cap_ok) begin
            fails++;
            $display("FAIL basic_frame_seen: got start/done missing, expected complete frame");
        end
        tests++;
        if (wait_cyc !== 1) begin
            fails++;
            $display("FAIL basic_start_latency: got %0d expected 1", wait_cyc);
        end
        tests++;
        if (cap_n !== hand_len) begin
            fails++;
            $display("FAIL basic_done_cycle: got %0d expected %0d", cap_n, hand_len);
        end
        tests++;
        if (start_cnt !== 1) begin
            fails++;
            $display("FAIL basic_start_count: got %0d expected 1", start_cnt);
        end
        tests++;
        if (cap[hand_len - 4] !== hand_fcs) begin
            fails++;
            $display("FAIL basic_fcs_hand: got %02h expected %02h", cap[hand_len - 4], hand_fcs);
        end
        for (int i = 0; i < exp_n; i++) begin
            tests++;
            if (cap[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL basic_byte[%0d]: got %02h expected %02h", i, cap[i], exp_b[i]);
            end
        end
        step();
        tests++;
        if ({done, busy, pl_rdy, data} !== {3'b001, 8'h00}) begin
            fails++;
            $display("FAIL basic_after_done: got done=%b busy=%b pl_rdy=%b data=%02h, expected 0 0 1 00",
                     done, busy, pl_rdy, data);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
        sink_ready = 1'b0;
        send_payload(3);
        for (int c = 0; c < 20; c++) begin
            if (pl_rdy !== 1'b0 || data !== 8'h00 || busy !== 1'b0 || start !== 1'b0) bad++;
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_hold: got %0d bad cycles expected 0", bad);
        end
        sink_ready = 1'b1;
        build_expected(3);
        capture_frame();
        tests++;
        if (wait_cyc !== 1) begin
            fails++;
            $display("FAIL backpressure_start_latency: got %0d expected 1", wait_cyc);
        end
        tests++;
        if (!cap_ok || cap_n !== exp_n) begin
            fails++;
            $display("FAIL backpressure_length: got %0d (ok=%b) expected %0d", cap_n, cap_ok, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            tests++;
            if (cap[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL backpressure_byte[%0d]: got %02h expected %02h", i, cap[i], exp_b[i]);
            end
        end
        step();
    endtask

    task automatic test_overflow();
        int err_cnt;
        int err_at;
        int start_seen;
        err_cnt    = 0;
        err_at     = -1;
        start_seen = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            pl_vld  = 1'b1;
            pl_data = 8'(i);
            pl_last = 1'b0;
            step();
            if (err === 1'b1) begin err_cnt++; err_at = i; end
            if (start === 1'b1) start_seen++;
        end
        pl_vld = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (err === 1'b1) err_cnt++;
            if (start === 1'b1) start_seen++;
        end
        tests++;
        if (err_cnt !== 1 || err_at !== DEPTH) begin
            fails++;
            $display("FAIL overflow_err: got %0d pulses at byte %0d, expected 1 pulse at byte %0d",
                     err_cnt, err_at, DEPTH);
        end
        tests++;
        if (start_seen !== 0) begin
            fails++;
            $display("FAIL overflow_no_start: got %0d starts expected 0", start_seen);
        end
        tests++;
        if (pl_rdy !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL overflow_idle: got pl_rdy=%b busy=%b expected 1 0", pl_rdy, busy);
        end
        // The next payload must transmit cleanly after the discard.
        pay[0] = 8'h5A; pay[1] = 8'hC3;
        send_payload(2);
        build_expected(2);
        capture_frame();
        tests++;
        if (!cap_ok || cap_n !== exp_n) begin
            fails++;
            $display("FAIL after_overflow_length: got %0d (ok=%b) expected %0d", cap_n, cap_ok, exp_n);
        end
        tests++;
`ifdef ETH_TX_PAD_EN
        if ({cap[20], cap[21]} !== 16'h002E) begin
`else
        if ({cap[20], cap[21]} !== 16'h0002) begin
`endif
            fails++;
            $display("FAIL after_overflow_len_field: got %02h %02h", cap[20], cap[21]);
        end
        for (int i = 0; i < exp_n; i++) begin
            tests++;
            if (cap[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL after_overflow_byte[%0d]: got %02h expected %02h", i, cap[i], exp_b[i]);
            end
        end
        step();
    endtask

    task automatic test_short_payload();
        logic [7:0] hand_fcs;
        logic [15:0] hand_lenf;
        int          hand_cycles;
`ifdef ETH_TX_PAD_EN
        hand_fcs    = 8'h79;
        hand_lenf   = 16'h002E;
        hand_cycles = 72;
`else
        hand_fcs    = 8'hA6;
        hand_lenf   = 16'h0001;
        hand_cycles = 27;
`endif
        pay[0] = 8'hFF;
        send_payload(1);
        tests++;
        if (pl_rdy !== 1'b0) begin
            fails++;
            $display("FAIL short_pl_rdy_low: got %b expected 0", pl_rdy);
        end
        build_expected(1);
        capture_frame();
        tests++;
        if (!cap_ok || cap_n !== hand_cycles) begin
            fails++;
            $display("FAIL short_length: got %0d (ok=%b) expected %0d", cap_n, cap_ok, hand_cycles);
        end
        tests++;
        if ({cap[20], cap[21]} !== hand_lenf) begin
            fails++;
            $display("FAIL short_len_field: got %02h%02h expected %04h", cap[20], cap[21], hand_lenf);
        end
        tests++;
        if (cap[hand_cycles - 1] !== hand_fcs) begin
            fails++;
            $display("FAIL short_fcs_hand: got %02h expected %02h", cap[hand_cycles - 1], hand_fcs);
        end
        for (int i = 0; i < exp_n; i++) begin
            tests++;
            if (cap[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL short_byte[%0d]: got %02h expected %02h", i, cap[i], exp_b[i]);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int done_seen;
        w         = 0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) pay[i] = 8'(i * 3 + 1);
        send_payload(10);
        while (!start && w < 200) begin step(); w++; end
        tests++;
        if (start !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_start: got no start expected start");
        end
        for (int c = 0; c < 24; c++) step();
        tests++;
        if (data !== pay[2] || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_in_payload: got data=%02h busy=%b expected %02h 1", data, busy, pay[2]);
        end
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if ({data, start, busy, done, err, pl_rdy} !== {8'h00, 5'b00001}) begin
            fails++;
            $display("FAIL reset_mid_outputs: got data=%02h start=%b busy=%b done=%b err=%b pl_rdy=%b, expected 00 0 0 0 0 1",
                     data, start, busy, done, err, pl_rdy);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done === 1'b1 || start === 1'b1) done_seen++;
        end
        tests++;
        if (done_seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: got %0d done/start events expected 0", done_seen);
        end
        pay[0] = 8'h77; pay[1] = 8'h88; pay[2] = 8'h99;
        send_payload(3);
        build_expected(3);
        capture_frame();
        tests++;
        if (!cap_ok || cap_n !== exp_n) begin
            fails++;
            $display("FAIL reset_mid_next_length: got %0d (ok=%b) expected %0d", cap_n, cap_ok, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            tests++;
            if (cap[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL reset_mid_next_byte[%0d]: got %02h expected %02h", i, cap[i], exp_b[i]);
            end
        end
        step();
    endtask

    task automatic test_full_buffer();
        for (int i = 0; i < DEPTH; i++) pay[i] = 8'($urandom_range(0, 255));
        send_payload(DEPTH);
        tests++;
        if (err !== 1'b0 || pl_rdy !== 1'b0) begin
            fails++;
            $display("FAIL full_accept: got err=%b pl_rdy=%b expected 0 0", err, pl_rdy);
        end
        build_expected(DEPTH);
        capture_frame();
        tests++;
        if (!cap_ok || cap_n !== 26 + DEPTH) begin
            fails++;
            $display("FAIL full_length: got %0d (ok=%b) expected %0d", cap_n, cap_ok, 26 + DEPTH);
        end
        for (int i = 0; i < exp_n; i++) begin
            tests++;
            if (cap[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL full_byte[%0d]: got %02h expected %02h", i, cap[i], exp_b[i]);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_short_payload();
        test_reset_mid_frame();
        test_full_buffer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
